// File: rtl/sbox_share_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sbox_share_ctrl_pkg
// Purpose  : Shared types and constants for the S-box sharing controller:
//            FSM state encoding, requester identifiers, byte counts and the
//            byte-index width used by the tag pipeline.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sbox_share_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        REQ_ST = 1'b0,
        REQ_KW = 1'b1
    } req_e;

    localparam int NBYTES_ST    = 16;
    localparam int NBYTES_KW    = 4;
    localparam int SBOX_LAT_MAX = 8;
    localparam int IDX_W        = 4;

    // FIPS-197 RotWord: cyclic left rotation of the word by one byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_share_tagpipe.sv
`default_nettype none
// ============================================================================
// Module   : sbox_share_tagpipe
// Purpose  : SBOX_LAT-deep shift register carrying {valid, byte index} in
//            lock-step with the external S-box so each S-box result can be
//            steered to its byte slot. Synchronous active-low clear drops
//            every in-flight tag.
// Ports    : clk        - clock
//            rst_n      - synchronous active-low clear
//            in_valid   - a byte is issued to the S-box this cycle
//            in_idx     - index of the issued byte
//            out_valid  - tag emerging alongside the current S-box result
//            out_idx    - byte index of that result
// Params   : SBOX_LAT   - S-box latency, 1..SBOX_LAT_MAX
// Revision : 1.0 - initial release
// ============================================================================
module sbox_share_tagpipe
    import sbox_share_ctrl_pkg::*;
#(
    parameter int SBOX_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic [IDX_W:0] r_pipe [SBOX_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SBOX_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= {in_valid, in_idx};
            for (int i = 1; i < SBOX_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign {out_valid, out_idx} = r_pipe[SBOX_LAT-1];

endmodule
`default_nettype wire

// File: rtl/sbox_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sbox_share_ctrl
// Purpose  : Time-multiplexes one external registered AES S-box between the
//            round datapath (SubBytes, 16 bytes) and the key schedule
//            (SubWord, 4 bytes). One byte is issued per cycle, results are
//            steered back by a tag pipeline and reassembled.
// Ports    : clk, rst_n (sync, active low)
//            st_valid/st_ready/st_in[127:0]         - state request
//            st_out_valid/st_out_ready/st_out[127:0] - SubBytes result
//            kw_valid/kw_ready/kw_in[31:0]          - key word request
//            kw_out_valid/kw_out_ready/kw_out[31:0] - SubWord result
//            sbox_x[7:0] (to S-box), sbox_y[7:0] (from S-box)
// Params   : SBOX_LAT - S-box latency in cycles, 1..8
// Macro    : SBOX_SHARE_CTRL_ROTWORD_EN - when defined, the key word is
//            rotated (RotWord) before substitution.
// Revision : 1.0 - initial release
// ============================================================================
module sbox_share_ctrl
    import sbox_share_ctrl_pkg::*;
#(
    parameter int SBOX_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_in,
    output logic         st_out_valid,
    input  logic         st_out_ready,
    output logic [127:0] st_out,
    input  logic         kw_valid,
    output logic         kw_ready,
    input  logic [31:0]  kw_in,
    output logic         kw_out_valid,
    input  logic         kw_out_ready,
    output logic [31:0]  kw_out,
    output logic [7:0]   sbox_x,
    input  logic [7:0]   sbox_y
);

    localparam logic [1:0] c_IDLE  = IDLE;
    localparam logic [1:0] c_ISSUE = ISSUE;
    localparam logic [1:0] c_DRAIN = DRAIN;
    localparam logic [1:0] c_DONE  = DONE;

    logic [1:0]       r_state;
    req_e             r_req;
    req_e             r_last;      // requester served most recently
    logic [127:0]     r_data;      // latched operand, byte k at [8k+:8]
    logic [127:0]     r_res;       // reassembled result, byte k at [8k+:8]
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_last_idx;
    logic             r_st_ov;
    logic             r_kw_ov;
    logic [127:0]     r_st_out;
    logic [31:0]      r_kw_out;

    logic             w_gnt_st;
    logic             w_gnt_kw;
    logic             w_tag_v;
    logic [IDX_W-1:0] w_tag_idx;
    logic [127:0]     w_res_nxt;
    logic             w_last_wr;
    logic [31:0]      w_kw_lat;
    logic [127:0]     w_kw_bytes;
    logic [31:0]      w_kw_res;
    logic             w_out_hs;

    // On a tie the requester that was not served last wins.
    assign w_gnt_st = st_valid && (!kw_valid || (r_last == REQ_KW));
    assign w_gnt_kw = kw_valid && !w_gnt_st;
    assign st_ready = (r_state == c_IDLE) && w_gnt_st;
    assign kw_ready = (r_state == c_IDLE) && w_gnt_kw;

    assign sbox_x = (r_state == c_ISSUE) ? r_data[{r_cnt, 3'b000} +: 8] : 8'h00;

`ifdef SBOX_SHARE_CTRL_ROTWORD_EN
    assign w_kw_lat = rot_word(kw_in);
`else
    assign w_kw_lat = kw_in;
`endif

    // Key word bytes are MSB-first; store them LSB-first so both requesters
    // share the same byte-k addressing in r_data/r_res.
    always_comb begin
        w_kw_bytes = '0;
        for (int i = 0; i < NBYTES_KW; i++) begin
            w_kw_bytes[8*i +: 8] = w_kw_lat[31-8*i -: 8];
        end
    end

    sbox_share_tagpipe #(
        .SBOX_LAT (SBOX_LAT)
    ) u_tagpipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (r_state == c_ISSUE),
        .in_idx    (r_cnt),
        .out_valid (w_tag_v),
        .out_idx   (w_tag_idx)
    );

    // Result with this cycle's emerging byte merged in, so the final byte
    // can be forwarded to the output register on the same edge.
    always_comb begin
        w_res_nxt = r_res;
        if (w_tag_v) begin
            w_res_nxt[{w_tag_idx, 3'b000} +: 8] = sbox_y;
        end
    end

    always_comb begin
        w_kw_res = '0;
        for (int i = 0; i < NBYTES_KW; i++) begin
            w_kw_res[31-8*i -: 8] = w_res_nxt[8*i +: 8];
        end
    end

    assign w_last_wr = w_tag_v && (w_tag_idx == r_last_idx);
    assign w_out_hs  = ((r_req == REQ_ST) && st_out_ready) ||
                       ((r_req == REQ_KW) && kw_out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_req      <= REQ_ST;
            r_last     <= REQ_KW;
            r_data     <= '0;
            r_res      <= '0;
            r_cnt      <= '0;
            r_last_idx <= '0;
            r_st_ov    <= 1'b0;
            r_kw_ov    <= 1'b0;
            r_st_out   <= '0;
            r_kw_out   <= '0;
        end else begin
            r_res <= w_res_nxt;
            case (r_state)
                c_IDLE: begin
                    if (st_valid && st_ready) begin
                        r_data     <= st_in;
                        r_req      <= REQ_ST;
                        r_last_idx <= IDX_W'(NBYTES_ST - 1);
                        r_cnt      <= '0;
                        r_state    <= c_ISSUE;
                    end else if (kw_valid && kw_ready) begin
                        r_data     <= w_kw_bytes;
                        r_req      <= REQ_KW;
                        r_last_idx <= IDX_W'(NBYTES_KW - 1);
                        r_cnt      <= '0;
                        r_state    <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == r_last_idx) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    // SBOX_LAT >= 1, so the last tag always emerges here.
                    if (w_last_wr) begin
                        r_state <= c_DONE;
                        if (r_req == REQ_ST) begin
                            r_st_out <= w_res_nxt;
                            r_st_ov  <= 1'b1;
                        end else begin
                            r_kw_out <= w_kw_res;
                            r_kw_ov  <= 1'b1;
                        end
                    end
                end
                c_DONE: begin
                    if (w_out_hs) begin
                        r_st_ov <= 1'b0;
                        r_kw_ov <= 1'b0;
                        r_last  <= r_req;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign st_out_valid = r_st_ov;
    assign kw_out_valid = r_kw_ov;
    assign st_out       = r_st_out;
    assign kw_out       = r_kw_out;

endmodule
`default_nettype wire

// File: tb/tb_sbox_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbox_share_ctrl
// Purpose  : Self-checking bench for sbox_share_ctrl. Instance a uses
//            SBOX_LAT=1, instance b uses SBOX_LAT=4; each has its own S-box
//            model built from GF(2^8) arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sbox_share_ctrl;

    logic         clk;
    logic         rst_n;
    logic         st_valid, kw_valid, st_out_ready, kw_out_ready;
    logic [127:0] st_in;
    logic [31:0]  kw_in;
    logic         b_en;

    logic         a_st_ready, a_st_ov, a_kw_ready, a_kw_ov;
    logic [127:0] a_st_out;
    logic [31:0]  a_kw_out;
    logic [7:0]   a_x, a_y;

    logic         b_st_ready, b_st_ov, b_kw_ready, b_kw_ov;
    logic [127:0] b_st_out;
    logic [31:0]  b_kw_out;
    logic [7:0]   b_x, b_y;
    logic [7:0]   b_d [4];

    logic [7:0]   sbox_tab [256];
    int           checks;
    int           errors;

    typedef struct {
        logic         is_kw;
        logic [127:0] din;
        logic [127:0] exp;
        int           lat;
    } vec_t;
    vec_t vecs [5];

    sbox_share_ctrl #(.SBOX_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(a_st_ready), .st_in(st_in),
        .st_out_valid(a_st_ov), .st_out_ready(st_out_ready), .st_out(a_st_out),
        .kw_valid(kw_valid), .kw_ready(a_kw_ready), .kw_in(kw_in),
        .kw_out_valid(a_kw_ov), .kw_out_ready(kw_out_ready), .kw_out(a_kw_out),
        .sbox_x(a_x), .sbox_y(a_y)
    );

    sbox_share_ctrl #(.SBOX_LAT(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid & b_en), .st_ready(b_st_ready), .st_in(st_in),
        .st_out_valid(b_st_ov), .st_out_ready(st_out_ready), .st_out(b_st_out),
        .kw_valid(kw_valid & b_en), .kw_ready(b_kw_ready), .kw_in(kw_in),
        .kw_out_valid(b_kw_ov), .kw_out_ready(kw_out_ready), .kw_out(b_kw_out),
        .sbox_x(b_x), .sbox_y(b_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // S-box models: one registered stage, and four stages.
    always @(posedge clk) begin
        a_y     <= sbox_tab[a_x];
        b_d[0]  <= sbox_tab[b_x];
        b_d[1]  <= b_d[0];
        b_d[2]  <= b_d[1];
        b_d[3]  <= b_d[2];
    end
    assign b_y = b_d[3];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_tab[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] sub_word_ref(input logic [31:0] w);
        logic [31:0] v;
        logic [31:0] r;
`ifdef SBOX_SHARE_CTRL_ROTWORD_EN
        v = {w[23:0], w[31:24]};
`else
        v = w;
`endif
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_tab[v[8*i +: 8]];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a_st_out"}, a_st_out, '0);
        chk({tag, "_a_kw_out"}, {96'b0, a_kw_out}, '0);
        chk({tag, "_a_flags"}, {123'b0, a_st_ov, a_kw_ov, a_st_ready, a_kw_ready, 1'b0}, '0);
        chk({tag, "_a_x"}, {120'b0, a_x}, '0);
        chk({tag, "_b_outs"}, {b_st_out ^ {96'b0, b_kw_out}}, '0);
        chk({tag, "_b_flags_x"}, {116'b0, b_st_ov, b_kw_ov, b_st_ready, b_kw_ready, b_x}, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits (bounded) from the current negedge for the chosen out_valid of dut a.
    task automatic wait_a_ov(input logic is_kw, output int cyc);
        cyc = 0;
        for (int k = 0; k < 64; k++) begin
            if (is_kw ? a_kw_ov : a_st_ov) begin
                cyc = k;
                return;
            end
            @(negedge clk);
        end
        cyc = -1;
    endtask

    task automatic pulse_out_ready();
        st_out_ready = 1'b1;
        kw_out_ready = 1'b1;
        @(negedge clk);
        st_out_ready = 1'b0;
        kw_out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int la, lb;
        la = 0;
        lb = 0;
        @(negedge clk);
        if (v.is_kw) begin kw_valid = 1'b1; kw_in = v.din[31:0]; end
        else         begin st_valid = 1'b1; st_in = v.din;       end
        #1;
        chk({name, "_a_ready"}, v.is_kw ? a_kw_ready : a_st_ready, 1);
        if (b_en) chk({name, "_b_ready"}, v.is_kw ? b_kw_ready : b_st_ready, 1);
        @(negedge clk);
        st_valid = 1'b0;
        kw_valid = 1'b0;
        for (int k = 1; k < 64; k++) begin
            if (la == 0 && (v.is_kw ? a_kw_ov : a_st_ov)) la = k;
            if (lb == 0 && (v.is_kw ? b_kw_ov : b_st_ov)) lb = k;
            if (la != 0 && (!b_en || lb != 0)) break;
            @(negedge clk);
        end
        chk({name, "_a_latency"}, 128'(la), 128'(v.lat));
        chk({name, "_a_data"}, v.is_kw ? {96'b0, a_kw_out} : a_st_out, v.exp);
        if (b_en) begin
            chk({name, "_b_latency"}, 128'(lb), 128'(v.lat + 3));
            chk({name, "_b_data"}, v.is_kw ? {96'b0, b_kw_out} : b_st_out, v.exp);
        end
        pulse_out_ready();
        chk({name, "_a_ov_drop"}, {126'b0, a_st_ov, a_kw_ov}, '0);
        if (b_en) chk({name, "_b_ov_drop"}, {126'b0, b_st_ov, b_kw_ov}, '0);
    endtask

    localparam logic [127:0] FIPS_IN  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] FIPS_OUT = 128'h76abd7fe2b670130c56f6bf27b777c63;
`ifdef SBOX_SHARE_CTRL_ROTWORD_EN
    localparam logic [31:0] KW_EXP = 32'h8a84eb01;
`else
    localparam logic [31:0] KW_EXP = 32'h018a84eb;
`endif

    initial begin
        int   cyc;
        logic sp, kp, m_free, m_req, m_last, e_st_rdy, e_kw_rdy, e_ov;
        logic [127:0] sd, m_exp;
        logic [31:0]  kd;
        int   m_due;

        checks = 0;
        errors = 0;
        rst_n = 1'b0; b_en = 1'b0;
        st_valid = 1'b0; kw_valid = 1'b0; st_out_ready = 1'b0; kw_out_ready = 1'b0;
        st_in = '0; kw_in = '0;
        build_sbox();

        vecs[0] = '{1'b0, FIPS_IN, FIPS_OUT, 18};
        vecs[1] = '{1'b1, 128'h09cf4f3c, {96'b0, KW_EXP}, 6};
        vecs[2] = '{1'b0, 128'h0, {16{8'h63}}, 18};
        vecs[3] = '{1'b1, 128'hffffffff, {96'b0, 32'h16161616}, 6};
        vecs[4] = '{1'b0, {16{8'hff}}, {16{8'h16}}, 18};

        // Reset state
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Table-driven single requests on both latencies
        b_en = 1'b1;
        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Tie after reset, backpressure, tie across DONE->IDLE
        b_en = 1'b0;
        do_reset();
        st_valid = 1'b1; st_in = FIPS_IN;
        kw_valid = 1'b1; kw_in = 32'h09cf4f3c;
        #1;
        chk("tie1_st_ready", a_st_ready, 1);
        chk("tie1_kw_ready", a_kw_ready, 0);
        @(negedge clk);
        st_in = 128'h0;              // a second state request, held
        wait_a_ov(1'b0, cyc);
        chk("tie1_st_seen", 128'(cyc >= 0), 1);
        chk("tie1_st_data", a_st_out, FIPS_OUT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("bp_st_ov", a_st_ov, 1);
            chk("bp_st_out", a_st_out, FIPS_OUT);
            chk("bp_readies", {a_st_ready, a_kw_ready}, 0);
        end
        pulse_out_ready();
        #1;
        chk("tie2_kw_ready", a_kw_ready, 1);
        chk("tie2_st_ready", a_st_ready, 0);
        @(negedge clk);
        kw_valid = 1'b0;
        wait_a_ov(1'b1, cyc);
        chk("tie2_kw_seen", 128'(cyc >= 0), 1);
        chk("tie2_kw_data", {96'b0, a_kw_out}, {96'b0, KW_EXP});
        pulse_out_ready();
        #1;
        chk("tie3_st_ready", a_st_ready, 1);
        @(negedge clk);
        st_valid = 1'b0;
        wait_a_ov(1'b0, cyc);
        chk("tie3_st_data", a_st_out, {16{8'h63}});
        pulse_out_ready();

        // Reset in the middle of ISSUE, at byte 7
        b_en = 1'b1;
        st_valid = 1'b1; st_in = FIPS_IN;
        @(negedge clk);
        st_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_a_x7", {120'b0, a_x}, 128'h07);
        chk("mid_b_x7", {120'b0, b_x}, 128'h07);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        rst_n = 1'b1;
        run_vec(vecs[2], "after_rst");

        // Randomized traffic against a transaction-level model (dut a)
        b_en = 1'b0;
        do_reset();
        sp = 1'b0; kp = 1'b0; sd = '0; kd = '0;
        m_free = 1'b1; m_req = 1'b0; m_last = 1'b1; m_due = 0; m_exp = '0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (!sp && $urandom_range(3) == 0) begin
                sp = 1'b1;
                sd = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!kp && $urandom_range(3) == 0) begin
                kp = 1'b1;
                kd = $urandom;
            end
            st_valid = sp; st_in = sd;
            kw_valid = kp; kw_in = kd;
            st_out_ready = ($urandom_range(2) != 0);
            kw_out_ready = ($urandom_range(2) != 0);
            #1;
            e_st_rdy = m_free && sp && (!kp || m_last);
            e_kw_rdy = m_free && kp && !e_st_rdy;
            e_ov     = !m_free && (c >= m_due);
            chk("rnd_st_ready", a_st_ready, e_st_rdy);
            chk("rnd_kw_ready", a_kw_ready, e_kw_rdy);
            chk("rnd_st_ov", a_st_ov, e_ov && !m_req);
            chk("rnd_kw_ov", a_kw_ov, e_ov && m_req);
            if (e_ov) chk("rnd_data", m_req ? {96'b0, a_kw_out} : a_st_out, m_exp);
            if (e_ov && (m_req ? kw_out_ready : st_out_ready)) begin
                m_free = 1'b1;
                m_last = m_req;
            end else if (e_st_rdy) begin
                m_free = 1'b0; m_req = 1'b0;
                m_due = c + 16 + 1 + 1;
                m_exp = sub_bytes(sd);
                sp = 1'b0;
            end else if (e_kw_rdy) begin
                m_free = 1'b0; m_req = 1'b1;
                m_due = c + 4 + 1 + 1;
                m_exp = {96'b0, sub_word_ref(kd)};
                kp = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
